// File: rtl/weight_update_module_pkg.sv
// Shared constants and FSM encoding for the weight update engine.
// Parameter index map: w3 at 0..19, w2 at 20..64, b3 at 65..68, b2 at 69..73.
package weight_update_module_pkg;

    localparam int FRAC_BITS  = 8;
    localparam int IDXW       = 7;

    // Each region base is derived from the previous region's base and size.
    localparam int W3_BASE    = 0;
    localparam int W2_BASE    = W3_BASE + 4 * 5;
    localparam int B3_BASE    = W2_BASE + 5 * 9;
    localparam int B2_BASE    = B3_BASE + 4;
    localparam int NUM_PARAMS = B2_BASE + 5;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/weight_update_module_fxp_mul_sat.sv
// Fixed-point arithmetic for the update pipeline: lr*dw scaled back to Q8.8,
// and the saturating subtract that produces the new parameter value.
module fxp_mul_sat
    import weight_update_module_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic [COEF_W-1:0] lr,
    input  logic [DATA_W-1:0] dw,
    output logic [DATA_W+1:0] s,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W+1:0] s_in,
    output logic [DATA_W-1:0] w_new
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = DATA_W + 2;

    // Clamp an 18-bit difference to the signed 16-bit range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] x);
        logic [2:0] top;
        top = x[SUM_W-1:DATA_W-1];
        if (top == 3'b000 || top == 3'b111)
            sat = x[DATA_W-1:0];
        else if (x[SUM_W-1])
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat = {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [SUM_W-1:0]  diff;

    always_comb begin
        prod    = PROD_W'($signed(lr)) * PROD_W'($signed(dw));
        shifted = prod >>> FRAC_BITS;
        s       = SUM_W'(shifted);
    end

    always_comb begin
        diff  = SUM_W'($signed(w)) - $signed(s_in);
        w_new = sat(diff);
    end

endmodule

// File: rtl/weight_update_module.sv
// Applies one pass of gradient deltas (w -= lr*dw) to a 74-entry Q8.8
// parameter file through a two-stage pipeline with same-index forwarding.
module weight_update_module
    import weight_update_module_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COEF_W-1:0] lr,
    input  logic              dw_valid,
    output logic              dw_ready,
    input  logic [IDXW-1:0]   dw_idx,
    input  logic [DATA_W-1:0] dw_data,
    input  logic              init_en,
    input  logic [IDXW-1:0]   init_idx,
    input  logic [DATA_W-1:0] init_data,
    input  logic [IDXW-1:0]   rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [IDXW-1:0]   upd_count
);

    localparam int SUM_W = DATA_W + 2;
    localparam int DRW   = $clog2(STAGES + 1);
    localparam logic [IDXW-1:0] NUM_IDX  = IDXW'(NUM_PARAMS);
    localparam logic [IDXW-1:0] LAST_CNT = IDXW'(NUM_PARAMS - 1);
    localparam logic [DRW-1:0]  LAST_DR  = DRW'(STAGES - 1);

    state_t state, state_nxt;

    logic [DRW-1:0]    drain_cnt;
    logic [COEF_W-1:0] lr_q;
    logic [DATA_W-1:0] regs [NUM_PARAMS];
    logic              hs;
    logic              init_we;

    logic              vld_p1, inr_p1;
    logic [IDXW-1:0]   idx_p1;
    logic [DATA_W-1:0] dw_p1;
    logic [SUM_W-1:0]  s_p1;
    logic [DATA_W-1:0] w_rd;
    logic              fwd;

    logic              vld_p2, inr_p2, wr_p2;
    logic [IDXW-1:0]   idx_p2;
    logic [SUM_W-1:0]  s_p2;
    logic [DATA_W-1:0] w_p2;
    logic [DATA_W-1:0] w_new;

    assign hs      = dw_valid && dw_ready;
    assign init_we = init_en && (state == IDLE) && (init_idx < NUM_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dw_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = COLLECT;
            end
            COLLECT: begin
                dw_ready = 1'b1;
                if (dw_valid && upd_count == LAST_CNT)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == LAST_DR)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_count <= '0;
            lr_q      <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                upd_count <= '0;
                lr_q      <= lr;
            end else if (hs) begin
                upd_count <= upd_count + IDXW'(1);
            end
            if (state == DRAIN)
                drain_cnt <= drain_cnt + DRW'(1);
            else
                drain_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= hs;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1 boundary: capture the accepted delta.
    always_ff @(posedge clk) begin
        if (hs) begin
            idx_p1 <= dw_idx;
            dw_p1  <= dw_data;
            inr_p1 <= dw_idx < NUM_IDX;
        end
    end

    // Stage 1 -> 2 boundary: scaled step plus the operand it is subtracted
    // from, taken from stage 2's result when it targets the same entry.
    assign w_rd  = inr_p1 ? regs[idx_p1] : '0;
    assign fwd   = wr_p2 && (idx_p2 == idx_p1);
    assign wr_p2 = vld_p2 && inr_p2;

    always_ff @(posedge clk) begin
        idx_p2 <= idx_p1;
        inr_p2 <= inr_p1;
        s_p2   <= s_p1;
        w_p2   <= fwd ? w_new : w_rd;
    end

    fxp_mul_sat #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_arith (
        .lr    (lr_q),
        .dw    (dw_p1),
        .s     (s_p1),
        .w     (w_p2),
        .s_in  (s_p2),
        .w_new (w_new)
    );

    // Stage 2 boundary: write back; pipeline writes never overlap IDLE init writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PARAMS; i++)
                regs[i] <= '0;
        end else if (wr_p2) begin
            regs[idx_p2] <= w_new;
        end else if (init_we) begin
            regs[init_idx] <= init_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= (rd_idx < NUM_IDX) ? regs[rd_idx] : '0;
    end

endmodule

// File: tb/tb_weight_update_module.sv
// Self-checking bench for weight_update_module: directed vector table,
// hand-written multi-cycle sequences and randomized passes vs. a reference model.
module tb_weight_update_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] lr;
    logic        dw_valid;
    logic        dw_ready;
    logic [6:0]  dw_idx;
    logic [15:0] dw_data;
    logic        init_en;
    logic [6:0]  init_idx;
    logic [15:0] init_data;
    logic [6:0]  rd_idx;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [6:0]  upd_count;

    always #5 clk = ~clk;

    weight_update_module dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lr        (lr),
        .dw_valid  (dw_valid),
        .dw_ready  (dw_ready),
        .dw_idx    (dw_idx),
        .dw_data   (dw_data),
        .init_en   (init_en),
        .init_idx  (init_idx),
        .init_data (init_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .upd_count (upd_count)
    );

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int model [74];
    int pidx  [74];
    int pdw   [74];

    typedef struct {
        string       name;
        int          iidx;
        logic [15:0] ival;
        logic [15:0] lr;
        int          didx;
        logic [15:0] dw;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [5];

    always @(negedge clk) if (done) done_total++;

    initial begin
        #1000000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    // w -= floor(lr*dw / 256), clamped to the Q8.8 range; out-of-range indices are dropped.
    function automatic void model_apply(input logic [15:0] l, input int idx, input logic [15:0] d);
        int w;
        if (idx >= 74) return;
        w = model[idx] - ((s16(l) * s16(d)) >>> 8);
        if (w > 32767) w = 32767;
        else if (w < -32768) w = -32768;
        model[idx] = w;
    endfunction

    task automatic do_init(input int idx, input logic [15:0] val);
        @(negedge clk);
        init_en = 1'b1; init_idx = 7'(idx); init_data = val;
        @(negedge clk);
        init_en = 1'b0;
        model[idx] = s16(val);
    endtask

    task automatic read_entry(input int idx, output logic [15:0] val);
        @(negedge clk);
        rd_idx = 7'(idx);
        @(negedge clk);
        val = rd_data;
    endtask

    task automatic check_all(input string name);
        logic [15:0] v;
        for (int i = 0; i < 74; i++) begin
            read_entry(i, v);
            chk($sformatf("%s[%0d]", name, i), int'(v), model[i] & 32'hFFFF);
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk({name, " return to idle"}, int'(busy), 0);
    endtask

    task automatic run_pass(input string name, input logic [15:0] l, input bit gaps,
                            input int inject_at, input int abort_at);
        int base;
        base = done_total;
        @(negedge clk);
        start = 1'b1; lr = l;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 74; k++) begin
            if (k == abort_at) begin
                dw_valid = 1'b0;
                rst = 1'b1;
                #1;
                chk({name, " busy in reset"}, int'(busy), 0);
                chk({name, " upd_count in reset"}, int'(upd_count), 0);
                chk({name, " dw_ready in reset"}, int'(dw_ready), 0);
                chk({name, " rd_data in reset"}, int'(rd_data), 0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 74; i++) model[i] = 0;
                repeat (6) @(negedge clk);
                chk({name, " no done after reset"}, done_total - base, 0);
                chk({name, " idle after reset"}, int'(busy), 0);
                return;
            end
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    dw_valid = 1'b0;
                    @(negedge clk);
                end
            end
            dw_valid = 1'b1; dw_idx = 7'(pidx[k]); dw_data = 16'(pdw[k]);
            if (k == inject_at) begin
                start = 1'b1; lr = 16'h7FFF;
                init_en = 1'b1; init_idx = 7'd3; init_data = 16'h1234;
            end
            @(negedge clk);
            start = 1'b0; init_en = 1'b0;
            model_apply(l, pidx[k], 16'(pdw[k]));
        end
        dw_valid = 1'b0;
        chk({name, " dw_ready after last"}, int'(dw_ready), 0);
        wait_idle(name);
        chk({name, " done pulses"}, done_total - base, 1);
        chk({name, " upd_count"}, int'(upd_count), 74);
    endtask

    initial begin
        logic [15:0] v;

        rst = 1'b1; start = 1'b0; lr = '0; dw_valid = 1'b0; dw_idx = '0; dw_data = '0;
        init_en = 1'b0; init_idx = '0; init_data = '0; rd_idx = '0;
        for (int i = 0; i < 74; i++) model[i] = 0;

        vt[0] = '{"basic",    0,  16'h0200, 16'h0100, 0,  16'h0080, 16'h0180};
        vt[1] = '{"sat_hi",   65, 16'h7F00, 16'h0100, 65, 16'hFE00, 16'h7FFF};
        vt[2] = '{"sat_lo",   69, 16'h8100, 16'h0100, 69, 16'h0200, 16'h8000};
        vt[3] = '{"trunc_p",  5,  16'h0000, 16'h0080, 5,  16'h0001, 16'h0000};
        vt[4] = '{"trunc_n",  6,  16'h0000, 16'h0080, 6,  16'hFFFF, 16'h0001};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset dw_ready", int'(dw_ready), 0);
        chk("reset upd_count", int'(upd_count), 0);
        chk("reset rd_data", int'(rd_data), 0);
        rst = 1'b0;
        @(negedge clk);
        read_entry(73, v);
        chk("post-reset entry 73", int'(v), 0);

        foreach (vt[i]) begin
            do_init(vt[i].iidx, vt[i].ival);
            for (int k = 0; k < 74; k++) begin
                pidx[k] = k;
                pdw[k]  = (k == vt[i].didx) ? int'(vt[i].dw) : 0;
            end
            run_pass(vt[i].name, vt[i].lr, i[0], -1, -1);
            read_entry(vt[i].didx, v);
            chk({vt[i].name, " result"}, int'(v), int'(vt[i].exp));
        end

        // Latency: the new value appears on rd_data 3 edges after the handshake edge.
        do_init(10, 16'h0000);
        rd_idx = 7'd10;
        @(negedge clk);
        start = 1'b1; lr = 16'h0100;
        @(negedge clk);
        start = 1'b0; dw_valid = 1'b1; dw_idx = 7'd10; dw_data = 16'h0100;
        @(negedge clk);
        dw_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("latency edge+2 old value", int'(rd_data), 0);
        @(negedge clk);
        chk("latency edge+3 new value", int'(rd_data), 16'hFF00);
        model_apply(16'h0100, 10, 16'h0100);
        for (int k = 1; k < 74; k++) begin
            dw_valid = 1'b1; dw_idx = 7'(k); dw_data = 16'h0000;
            @(negedge clk);
        end
        dw_valid = 1'b0;
        wait_idle("latency pass");
        chk("latency pass upd_count", int'(upd_count), 74);

        // Back-to-back deltas to the same entry accumulate.
        do_init(30, 16'h0000);
        for (int k = 0; k < 74; k++) begin pidx[k] = k; pdw[k] = 0; end
        pidx[0] = 30; pdw[0] = 16'h0100;
        pidx[1] = 30; pdw[1] = 16'h0100;
        run_pass("hazard", 16'h0100, 1'b0, -1, -1);
        read_entry(30, v);
        chk("hazard result", int'(v), 16'hFE00);

        // Out-of-range index is counted but changes nothing.
        for (int k = 0; k < 74; k++) begin pidx[k] = k; pdw[k] = 0; end
        pidx[5] = 100; pdw[5] = 16'h4000;
        run_pass("idx100", 16'h0100, 1'b0, -1, -1);
        check_all("idx100");

        // start, init_en and a changed lr during COLLECT have no effect.
        for (int k = 0; k < 74; k++) begin
            pidx[k] = $urandom_range(0, 73);
            pdw[k]  = int'($urandom_range(0, 65535));
        end
        run_pass("collect inject", 16'h0080, 1'b1, 20, -1);
        check_all("collect inject");

        for (int p = 0; p < 3; p++) begin
            logic [15:0] l;
            l = 16'($urandom_range(0, 512) - 256);
            for (int k = 0; k < 74; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0) pidx[k] = pidx[k-1];
                else pidx[k] = $urandom_range(0, 79);
                pdw[k] = int'($urandom_range(0, 65535));
            end
            run_pass($sformatf("random%0d", p), l, 1'b1, -1, -1);
            check_all($sformatf("random%0d", p));
        end

        // Reset in the middle of a pass wipes state and suppresses done.
        for (int k = 0; k < 74; k++) begin
            pidx[k] = $urandom_range(0, 73);
            pdw[k]  = int'($urandom_range(0, 65535));
        end
        run_pass("midpass reset", 16'h0100, 1'b0, -1, 10);
        check_all("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_update_module.md
WEIGHT_UPDATE_MODULE -- requirements
Module: weight_update_module

Interface
REQ-001 Parameters: NUM_PARAMS=74 (total trainable parameters); FRAC_BITS=8 (Q8.8 signed fixed point); IDXW=7 (index width).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins an update pass; honoured only in IDLE.
REQ-005 lr  in  16  signed Q8.8 learning rate; sampled on accepted start and held for the pass.
REQ-006 dw_valid  in  1  delta word valid.
REQ-007 dw_ready  out  1  delta word accepted when dw_valid&&dw_ready.
REQ-008 dw_idx  in  7  parameter index of the delta.
REQ-009 dw_data  in  16  signed Q8.8 gradient (deltaw3/deltaw2/deltab3/deltab2 value).
REQ-010 init_en  in  1  direct parameter write; honoured only in IDLE.
REQ-011 init_idx  in  7  direct-write index.  init_data  in  16  direct-write value.
REQ-012 rd_idx  in  7  read index.  rd_data  out  16  parameter value, registered, 1-cycle latency.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a pass completes.
REQ-015 upd_count  out  7  deltas accepted in the current or last pass.

Function
REQ-016 Index map: 0-19 w3[i][j] at i*5+j (i 0-3, j 0-4); 20-64 w2[i][j] at 20+i*9+j (i 0-4, j 0-8); 65-68 b3[0-3]; 69-73 b2[0-4].
REQ-017 Storage: 74x16 register file; every entry resets to 0.
REQ-018 FSM states: IDLE, COLLECT, DRAIN, DONE.
REQ-019 IDLE->COLLECT on start; upd_count cleared to 0; lr latched.
REQ-020 COLLECT: dw_ready=1; each handshake increments upd_count.
REQ-021 COLLECT->DRAIN on the handshake that brings upd_count to 74; dw_ready=0 from the next cycle.
REQ-022 DRAIN: lasts until the pipeline is empty (2 cycles); then ->DONE.
REQ-023 DONE: done=1 for exactly one cycle; then ->IDLE.
REQ-024 Outside COLLECT, dw_ready=0 and dw_valid is ignored.
REQ-025 Pipeline stage 1: p = lr*dw_data, 32-bit signed; s = p>>>FRAC_BITS (arithmetic shift, truncation toward -inf).
REQ-026 Pipeline stage 2: w_new = w - s, computed at 18 bits and saturated to [-32768, 32767]; written to the entry.
REQ-027 Latency: an accepted delta is visible on rd_data 3 cycles after its handshake cycle.
REQ-028 Back-to-back deltas to the same index: stage 2 forwards its own result, so both deltas are applied cumulatively. The pipeline accepts one delta per cycle with no stall.
REQ-029 dw_idx>=74: the handshake is accepted and counted, and no write occurs.
REQ-030 init_en in IDLE writes init_data immediately; init_en when not in IDLE is ignored.
REQ-031 start while busy is ignored.
REQ-032 rd_data reflects the register file state after the preceding edge, including writes that complete in the same cycle as the read.

Reset
REQ-033 rst asserted forces, asynchronously: FSM=IDLE, dw_ready=0, busy=0, done=0, upd_count=0, rd_data=0, pipeline valids=0, all parameters=0, latched lr=0.
REQ-034 rst mid-pass discards in-flight deltas; no partial write survives.

Structure
REQ-035 Shared package contents: NUM_PARAMS, FRAC_BITS, IDXW, the base offsets W3_BASE=0, W2_BASE=20, B3_BASE=65, B2_BASE=69, and the FSM state enum.
REQ-036 One sub-module, fxp_mul_sat, implements the stage-1 multiply/shift and the stage-2 subtract/saturate arithmetic; all control logic stays in the top module.

Verification
REQ-037 Basic update: init idx 0 = 0x0200; lr=0x0100; pass with idx 0 dw=0x0080, others dw=0 -> idx 0 reads 0x0180; done pulses once; upd_count=74.
REQ-038 Saturation: init idx 65 = 0x7F00; lr=0x0100; dw=0xFE00 -> 0x7FFF. Init idx 69 = 0x8100; dw=0x0200 -> 0x8000.
REQ-039 Truncation: lr=0x0080; dw=0x0001 on idx 5 (init 0) -> 0x0000. dw=0xFFFF on idx 6 (init 0) -> 0x0001.
REQ-040 Hazard: idx 30 init 0; lr=0x0100; consecutive-cycle deltas 0x0100, 0x0100 to idx 30 -> 0xFE00.
REQ-041 Boundary/protocol: dw_idx=100 in a pass -> counted, no entry changes. start and init_en during COLLECT -> ignored. Randomly gapped dw_valid -> completes after exactly 74 handshakes.
REQ-042 Reset mid-pass: rst after 10 handshakes -> all parameters 0, busy=0, no done pulse, upd_count=0.
